// File: rtl/nn_issue_ctrl.sv
// Multi-cycle issue controller: accepts one opcode at a time and sequences EX1/EX2/MEM/WB controls.
// Optional retire counter output enabled by macro NN_ISSUE_RETIRE_CNT_EN.
module nn_issue_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  opcode,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [2:0]  alu_ctrl1,
  output logic [2:0]  alu_ctrl2,
  output logic        busy,
  output logic        retire,
  output logic        illegal,
`ifdef NN_ISSUE_RETIRE_CNT_EN
  output logic [15:0] retire_cnt,
`endif
  output logic        mem_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EX1  = 3'd1,
    EX2  = 3'd2,
    MEM  = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_SLT = 4'h3;
  localparam logic [3:0] OP_MAC = 4'h4;
  localparam logic [3:0] OP_LD  = 4'hE;
  localparam logic [3:0] OP_ST  = 4'hF;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     stateR, nextStateS;
  logic [3:0] opcodeR;
  logic [7:0] memCntR, memCntNextS;
  logic       loadOpS, setIllegalS, setMemErrS;
  logic       illegalR, memErrR, retireS;

  function automatic logic isLegal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_MUL, OP_SLT, OP_MAC, OP_LD, OP_ST: isLegal = 1'b1;
      default:                                      isLegal = 1'b0;
    endcase
  endfunction

  // ALU stage pair {stage1, stage2}; stage2 111 means pass-through
  function automatic logic [5:0] aluDecode(input logic [3:0] op);
    case (op)
      OP_ADD:       aluDecode = 6'b000_111;
      OP_MUL:       aluDecode = 6'b001_111;
      OP_SLT:       aluDecode = 6'b010_111;
      OP_MAC:       aluDecode = 6'b001_000;
      OP_LD, OP_ST: aluDecode = 6'b000_111;
      default:      aluDecode = 6'b111_111;
    endcase
  endfunction

  // State, latched opcode, MEM wait counter and the registered error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR   <= IDLE;
      opcodeR  <= 4'h0;
      memCntR  <= 8'd0;
      illegalR <= 1'b0;
      memErrR  <= 1'b0;
    end else begin
      stateR   <= nextStateS;
      memCntR  <= memCntNextS;
      illegalR <= setIllegalS;
      memErrR  <= setMemErrS;
      if (loadOpS) begin
        opcodeR <= opcode;
      end
    end
  end

  // Next-state sequencing and MEM timeout detection
  always_comb begin
    nextStateS  = stateR;
    memCntNextS = memCntR;
    loadOpS     = 1'b0;
    setIllegalS = 1'b0;
    setMemErrS  = 1'b0;
    case (stateR)
      IDLE: begin
        memCntNextS = 8'd0;
        if (instr_valid && isLegal(opcode)) begin
          nextStateS = EX1;
          loadOpS    = 1'b1;
        end else if (instr_valid) begin
          setIllegalS = 1'b1;
        end else begin
          nextStateS = IDLE;
        end
      end
      EX1: begin
        memCntNextS = 8'd0;
        if (opcodeR == OP_MAC) begin
          nextStateS = EX2;
        end else if ((opcodeR == OP_LD) || (opcodeR == OP_ST)) begin
          nextStateS = MEM;
        end else begin
          nextStateS = WB;
        end
      end
      EX2: nextStateS = WB;
      MEM: begin
        if (mem_ack) begin
          nextStateS  = (opcodeR == OP_ST) ? IDLE : WB;
          memCntNextS = 8'd0;
        end else if (memCntR == TIMEOUT_LAST) begin
          nextStateS  = IDLE;
          memCntNextS = 8'd0;
          setMemErrS  = 1'b1;
        end else begin
          memCntNextS = memCntR + 8'd1;
        end
      end
      WB:      nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // ST retires in the acknowledged MEM cycle since it has no writeback
  assign retireS     = (stateR == WB) || ((stateR == MEM) && (opcodeR == OP_ST) && mem_ack);
  assign instr_ready = (stateR == IDLE);
  assign busy        = (stateR != IDLE);
  assign mem_req     = (stateR == MEM);
  assign mem_write   = (stateR == MEM) && (opcodeR == OP_ST);
  assign reg_write   = (stateR == WB);
  assign mem_to_reg  = (stateR == WB) && (opcodeR == OP_LD);
  assign retire      = retireS;
  assign illegal     = illegalR;
  assign mem_err     = memErrR;
  assign {alu_ctrl1, alu_ctrl2} = (stateR == IDLE) ? 6'b111_111 : aluDecode(opcodeR);

`ifdef NN_ISSUE_RETIRE_CNT_EN
  logic [15:0] retireCntR;

  // Free-running retire count, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retireCntR <= 16'd0;
    end else if (retireS) begin
      retireCntR <= retireCntR + 16'd1;
    end
  end

  assign retire_cnt = retireCntR;
`endif

endmodule

// File: tb/tb_nn_issue_ctrl.sv
// Directed self-checking bench for nn_issue_ctrl; output bundle compared after each edge.
module tb_nn_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic        mem_ack;
  logic        mem_req, mem_write, reg_write, mem_to_reg;
  logic [2:0]  alu_ctrl1, alu_ctrl2;
  logic        busy, retire, illegal, mem_err;
`ifdef NN_ISSUE_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int total = 0;
  int bad   = 0;

  nn_issue_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .mem_ack(mem_ack), .mem_req(mem_req), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_ctrl1(alu_ctrl1),
    .alu_ctrl2(alu_ctrl2), .busy(busy), .retire(retire), .illegal(illegal),
`ifdef NN_ISSUE_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Bundle order: ready busy req wr regw m2r retire illegal err alu1 alu2
  localparam logic [14:0] IDLE_V = 15'b1_0_0_0_0_0_0_0_0_111_111;

  function automatic logic [14:0] mk(input logic rdy, input logic bsy, input logic req,
                                     input logic wr, input logic rw, input logic m2r,
                                     input logic ret, input logic ill, input logic err,
                                     input logic [2:0] a1, input logic [2:0] a2);
    return {rdy, bsy, req, wr, rw, m2r, ret, ill, err, a1, a2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {instr_ready, busy, mem_req, mem_write, reg_write, mem_to_reg,
           retire, illegal, mem_err, alu_ctrl1, alu_ctrl2};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op);
    instr_valid = 1'b1;
    opcode      = op;
    tick();
    instr_valid = 1'b0;
  endtask

  // Two-cycle ALU op: EX1 then WB, back to IDLE
  task automatic runAlu(input string name, input logic [3:0] op, input logic [2:0] a1);
    issue(op);
    chk({name, "_ex1"}, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a1, 3'b111));
    tick();
    chk({name, "_wb"},  mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a1, 3'b111));
    tick();
    chk({name, "_idle"}, IDLE_V);
  endtask

  initial begin
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    opcode      = 4'h0;
    mem_ack     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset", IDLE_V);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset", IDLE_V);

    runAlu("add", 4'h1, 3'b000);
    runAlu("mul", 4'h2, 3'b001);
    runAlu("slt", 4'h3, 3'b010);

    // MAC with instr_valid held high while busy: must be ignored
    issue(4'h4);
    instr_valid = 1'b1;
    opcode      = 4'h1;
    chk("mac_ex1", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000));
    tick();
    chk("mac_ex2", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000));
    tick();
    chk("mac_wb",  mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000));
    instr_valid = 1'b0;
    tick();
    chk("mac_idle", IDLE_V);

    // LD: ack during EX1 is ignored, then ack on the third MEM cycle
    issue(4'hE);
    mem_ack = 1'b1;
    chk("ld_ex1", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    tick();
    mem_ack = 1'b0;
    chk("ld_mem1", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    tick();
    chk("ld_mem2", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    tick();
    mem_ack = 1'b1;
    chk("ld_mem3", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    tick();
    mem_ack = 1'b0;
    chk("ld_wb", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111));
    tick();
    chk("ld_idle", IDLE_V);

    // ST acknowledged in the first MEM cycle retires there
    issue(4'hF);
    chk("st_ex1", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    tick();
    mem_ack = 1'b1;
    #1;
    chk("st_mem_ack", mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111));
    tick();
    mem_ack = 1'b0;
    chk("st_idle", IDLE_V);

    // ST timeout: eight MEM cycles, then mem_err pulse in IDLE
    issue(4'hF);
    chk("sto_ex1", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("sto_mem%0d", i),
          mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    end
    tick();
    chk("sto_err", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 3'b111));
    tick();
    chk("sto_idle", IDLE_V);

    // Undefined opcodes
    issue(4'h0);
    chk("ill0_pulse", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b111));
    tick();
    chk("ill0_idle", IDLE_V);
    issue(4'h7);
    chk("ill7_pulse", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b111));
    tick();
    chk("ill7_idle", IDLE_V);

    // Asynchronous reset while LD sits in MEM
    issue(4'hE);
    tick();
    chk("rst_ld_mem", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", IDLE_V);
    mem_ack = 1'b1;
    tick();
    chk("rst_hold", IDLE_V);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("rst_release", IDLE_V);
    tick();
    chk("rst_no_pulse", IDLE_V);
    runAlu("add2", 4'h1, 3'b000);

`ifdef NN_ISSUE_RETIRE_CNT_EN
    rst_n = 1'b0;
    #1;
    total++;
    assert (retire_cnt === 16'h0000) else begin
      bad++;
      $error("FAIL cnt_reset observed=%h expected=0000", retire_cnt);
    end
    rst_n = 1'b1;
    tick();
    instr_valid = 1'b1;
    opcode      = 4'h1;
    for (int i = 0; i < 65535 * 3; i++) begin
      tick();
    end
    instr_valid = 1'b0;
    tick();
    tick();
    total++;
    assert (retire_cnt === 16'hFFFF) else begin
      bad++;
      $error("FAIL cnt_ffff observed=%h expected=ffff", retire_cnt);
    end
    runAlu("add_wrap", 4'h1, 3'b000);
    total++;
    assert (retire_cnt === 16'h0000) else begin
      bad++;
      $error("FAIL cnt_wrap observed=%h expected=0000", retire_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
